// File: rtl/icache_pkg.sv
// Shared icache definitions: default geometry and the read-data buffer entry.
package icache_pkg;

    localparam int unsigned DEF_NUM_WAYS    = 4;
    localparam int unsigned DEF_LINE_BITS   = 256;
    localparam int unsigned DEF_WORD_BITS   = 32;
    localparam int unsigned DEF_FETCH_WORDS = 2;

    localparam int unsigned WORDS_PER_LINE = DEF_LINE_BITS / DEF_WORD_BITS;
    localparam int unsigned WORD_IDX_BITS  = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFFSET_BITS    = $clog2(DEF_LINE_BITS / 8);

    typedef struct packed {
        logic [DEF_FETCH_WORDS*DEF_WORD_BITS-1:0] rdata;
        logic                                     err;
    } icache_rdata_entry_t;

endpackage

// File: rtl/icache_rdata_fifo2.sv
// Generic 2-entry in-order valid/ready buffer; push_ready depends only on registered state.
module icache_rdata_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t      state, state_nxt;
    logic [WIDTH-1:0] head, tail;
    logic             push, pop;
    logic             load_head, load_tail, head_from_tail;

    assign push_ready = (state != FIFO_FULL);
    assign pop_valid  = (state != FIFO_EMPTY);
    assign pop_data   = head;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FIFO_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            if (load_tail) tail <= push_data;
            if (load_head) head <= head_from_tail ? tail : push_data;
        end
    end

    // head register stays put after the last pop, so pop_data holds the popped value
    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            FIFO_EMPTY: begin
                if (push) begin
                    state_nxt = FIFO_ONE;
                    load_head = 1'b1;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nxt = FIFO_FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    state_nxt      = FIFO_ONE;
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = FIFO_EMPTY;
        endcase
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push_valid && push_ready && state == FIFO_FULL));
    end
`endif

endmodule

// File: rtl/icache_rdata_sel.sv
// Icache way select + fetch-window extraction feeding a 2-entry response buffer.
// Optional: define ICACHE_RDATA_ERRCNT_EN to add the saturating err_count output.
module icache_rdata_sel
    import icache_pkg::*;
#(
    parameter int unsigned NUM_WAYS    = DEF_NUM_WAYS,
    parameter int unsigned LINE_BITS   = DEF_LINE_BITS,
    parameter int unsigned WORD_BITS   = DEF_WORD_BITS,
    parameter int unsigned FETCH_WORDS = DEF_FETCH_WORDS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [NUM_WAYS*LINE_BITS-1:0]      way_lines,
    input  logic [NUM_WAYS-1:0]                hit_way,
    input  logic [$clog2(LINE_BITS/8)-1:0]     offset,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [FETCH_WORDS*WORD_BITS-1:0]   resp_rdata,
    output logic                               resp_err
`ifdef ICACHE_RDATA_ERRCNT_EN
    ,
    output logic [15:0]                        err_count
`endif
);

    localparam int unsigned WPL    = LINE_BITS / WORD_BITS;
    localparam int unsigned IDX_W  = $clog2(WPL);
    localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
    localparam int unsigned BYTE_W = $clog2(WORD_BITS / 8);
    localparam int unsigned DATA_W = FETCH_WORDS * WORD_BITS;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } entry_t;

    logic [LINE_BITS-1:0] line_sel;
    logic                 hit_legal;
    logic [IDX_W-1:0]     word_idx;
    logic [DATA_W-1:0]    window;
    logic                 unused_offset_lsbs;
    entry_t               push_entry;
    entry_t               head;

    // AND-OR mux: an illegal vector may merge lines, but the result is then discarded
    always_comb begin
        line_sel = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            line_sel = line_sel | (way_lines[i*LINE_BITS +: LINE_BITS] & {LINE_BITS{hit_way[i]}});
        end
    end

    assign hit_legal          = (hit_way != '0) && ((hit_way & (hit_way - NUM_WAYS'(1))) == '0);
    assign word_idx           = offset[OFF_W-1:BYTE_W];
    assign unused_offset_lsbs = ^offset[BYTE_W-1:0];

    // IDX_W-bit addition wraps modulo the words per line
    for (genvar k = 0; k < FETCH_WORDS; k++) begin : g_win
        logic [IDX_W-1:0] idx;
        assign idx = word_idx + IDX_W'(k);
        assign window[k*WORD_BITS +: WORD_BITS] = line_sel[idx*WORD_BITS +: WORD_BITS];
    end

    always_comb begin
        push_entry.rdata = hit_legal ? window : '0;
        push_entry.err   = !hit_legal;
    end

    icache_rdata_fifo2 #(
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (req_valid),
        .push_ready (req_ready),
        .push_data  (push_entry),
        .pop_valid  (resp_valid),
        .pop_ready  (resp_ready),
        .pop_data   (head)
    );

    assign resp_rdata = head.rdata;
    assign resp_err   = head.err;

`ifdef ICACHE_RDATA_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (req_valid && req_ready && !hit_legal && err_count != '1) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && resp_valid && resp_err) assert (resp_rdata == '0);
    end
`endif

endmodule

// File: tb/tb_icache_rdata_sel.sv
// Randomized + directed bench for icache_rdata_sel against a queue-based reference model.
module tb_icache_rdata_sel;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1023:0] way_lines;
    logic [3:0]    hit_way;
    logic [4:0]    offset;
    logic          resp_valid;
    logic          resp_ready;
    logic [63:0]   resp_rdata;
    logic          resp_err;
`ifdef ICACHE_RDATA_ERRCNT_EN
    logic [15:0]   err_count;
    logic [15:0]   m_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_rdata_sel #(
        .NUM_WAYS    (4),
        .LINE_BITS   (256),
        .WORD_BITS   (32),
        .FETCH_WORDS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .way_lines  (way_lines),
        .hit_way    (hit_way),
        .offset     (offset),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef ICACHE_RDATA_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {err, rdata} for a request, straight from the selection rules
    function automatic logic [64:0] model_resp(input logic [1023:0] lines, input logic [3:0] hit,
                                               input logic [4:0] off);
        int ones;
        int way;
        int w;
        logic [255:0] line;
        logic [63:0]  r;
        ones = 0;
        way  = 0;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
                ones++;
                way = i;
            end
        end
        if (ones != 1) return {1'b1, 64'h0};
        line = lines[way*256 +: 256];
        w    = int'(off) / 4;
        r    = '0;
        for (int k = 0; k < 2; k++) r[k*32 +: 32] = line[((w + k) % 8)*32 +: 32];
        return {1'b0, r};
    endfunction

    logic [64:0] q[$];
    logic        model_live = 1'b0;
    logic        m_pop, m_acc;
    logic [64:0] m_e;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
`ifdef ICACHE_RDATA_ERRCNT_EN
            m_cnt = 16'd0;
`endif
        end else begin
            m_pop = (q.size() > 0) && resp_ready;
            m_acc = req_valid && (q.size() < 2);
            m_e   = model_resp(way_lines, hit_way, offset);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(m_e);
`ifdef ICACHE_RDATA_ERRCNT_EN
                if (m_e[64] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end
        end
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("resp_valid", 64'(resp_valid), 64'(q.size() > 0));
            chk("req_ready", 64'(req_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("resp_rdata", resp_rdata, q[0][63:0]);
                chk("resp_err", 64'(resp_err), 64'(q[0][64]));
            end
`ifdef ICACHE_RDATA_ERRCNT_EN
            chk("err_count", 64'(err_count), 64'(m_cnt));
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random;
        for (int i = 0; i < 32; i++) way_lines[i*32 +: 32] = $urandom;
    endtask

    task automatic fill_way(input int way, input logic [31:0] base);
        for (int i = 0; i < 8; i++) way_lines[(way*8 + i)*32 +: 32] = base + 32'(i);
    endtask

    task automatic rand_req;
        logic [3:0] onehot;
        onehot = 4'b0001 << $urandom_range(0, 3);
        hit_way = ($urandom_range(0, 7) == 0) ? 4'($urandom) : onehot;
        offset  = 5'($urandom);
        fill_random();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        hit_way    = '0;
        offset     = '0;
        way_lines  = '0;
        @(negedge clk);
        tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        rst = 1'b0;

        // single legal request
        fill_random();
        fill_way(2, 32'h2000_0000);
        hit_way = 4'b0100; offset = 5'h08; req_valid = 1'b1; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("t1_valid", 64'(resp_valid), 64'd1);
        chk("t1_rdata", resp_rdata, 64'h2000_0003_2000_0002);
        chk("t1_err", 64'(resp_err), 64'd0);
        tick();

        // window wraps within the line
        fill_way(0, 32'h0000_00A0);
        hit_way = 4'b0001; offset = 5'h1C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("wrap_rdata", resp_rdata, 64'h0000_00A0_0000_00A7);
        tick();

        // illegal hit vectors
        hit_way = 4'b0000; req_valid = 1'b1;
        tick();
        chk("ill0_err", 64'(resp_err), 64'd1);
        chk("ill0_rdata", resp_rdata, 64'd0);
        hit_way = 4'b0011;
        tick();
        req_valid = 1'b0;
        chk("ill1_err", 64'(resp_err), 64'd1);
        chk("ill1_rdata", resp_rdata, 64'd0);
`ifdef ICACHE_RDATA_ERRCNT_EN
        chk("ill_errcnt", 64'(err_count), 64'd2);
`endif
        tick();

        // backpressure
        resp_ready = 1'b0; req_valid = 1'b1;
        fill_random();
        hit_way = 4'b0001; offset = 5'h00;
        tick();
        hit_way = 4'b0010; offset = 5'h04;
        tick();
        chk("bp_full", 64'(req_ready), 64'd0);
        hit_way = 4'b0100; offset = 5'h08;
        tick();
        chk("bp_still_full", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("bp_after_pop", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_third_head", 64'(resp_valid), 64'd1);
        chk("bp_third_rdata", resp_rdata, model_resp(way_lines, 4'b0100, 5'h08) & 65'h0_FFFF_FFFF_FFFF_FFFF);
        tick();
        chk("bp_drained", 64'(resp_valid), 64'd0);

        // continuous push/pop at one entry
        resp_ready = 1'b1; req_valid = 1'b1;
        rand_req();
        tick();
        for (int c = 0; c < 8; c++) begin
            rand_req();
            tick();
            chk("pp_valid", 64'(resp_valid), 64'd1);
            chk("pp_ready", 64'(req_ready), 64'd1);
        end
        req_valid = 1'b0;
        tick();

        // reset with two entries held
        resp_ready = 1'b0; req_valid = 1'b1;
        rand_req();
        tick();
        rand_req();
        tick();
        chk("rs_full", 64'(req_ready), 64'd0);
        req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_valid", 64'(resp_valid), 64'd0);
        chk("rs_ready", 64'(req_ready), 64'd1);
        fill_random();
        fill_way(1, 32'h5000_0000);
        hit_way = 4'b0010; offset = 5'h00; req_valid = 1'b1; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rs_new_rdata", resp_rdata, 64'h5000_0001_5000_0000);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            rand_req();
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
